// File: rtl/dpram_fifo_pkg.sv
// Shared constants, types and pointer helper for the distributed-RAM FIFO controller.
// The optional occupancy port is enabled by defining DPRAM_FIFO_LEVEL_EN.
package dpram_fifo_pkg;

  localparam int AW    = 4;   // RAM address width (16-deep slices)
  localparam int DEPTH = 16;  // words held in the RAM bank
  localparam int CNT_W = 5;   // RAM occupancy counter width (0..16)
  localparam int LVL_W = 5;   // total occupancy width (0..17)

  typedef logic [AW-1:0]    ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Pointers wrap naturally modulo DEPTH because DEPTH == 2**AW.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/dpram_fifo_outreg.sv
// Registered output stage of the FIFO: captures the asynchronous RAM read port
// on a load and drops out_valid when the consumer drains it without a refill.
module dpram_fifo_outreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_out_ready,
  input  logic [WIDTH-1:0] i_ram_q,
  output logic             o_out_valid,
  output logic [WIDTH-1:0] o_out_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // Load the head word from RAM, or drain the held word when it is taken without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_ram_q;
    end else if (r_valid && i_out_ready) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_out_valid = r_valid;
  assign o_out_data  = r_data;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external 16-deep distributed dual-port RAM bank.
// Capacity is 17 words: 16 in RAM plus one in the registered output stage.
// Define DPRAM_FIFO_LEVEL_EN to expose the 'level' occupancy port (ram words + output word).
module dpram_fifo_ctrl
  import dpram_fifo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ram_di,
  output logic [AW-1:0]    ram_wad,
  output logic             ram_wre,
  output logic [AW-1:0]    ram_rad,
  input  logic [WIDTH-1:0] ram_q
`ifdef DPRAM_FIFO_LEVEL_EN
  ,
  output logic [LVL_W-1:0] level
`endif
);

  ptr_t r_wptr;
  ptr_t r_rptr;
  cnt_t r_ram_cnt;

  logic w_full;
  logic w_ram_nonempty;
  logic w_push;
  logic w_load;
  logic w_out_valid;

  // in_ready depends only on registered state (and reset), never on out_ready.
  assign w_full         = (r_ram_cnt == cnt_t'(DEPTH));
  assign w_ram_nonempty = (r_ram_cnt != cnt_t'(0));
  assign in_ready       = ~rst & ~w_full;
  assign w_push         = in_valid & in_ready;

  // Refill the output stage whenever it is empty or being taken this cycle.
  // Because a load needs a stored word, rptr never points at the slot being written.
  assign w_load = w_ram_nonempty & (~w_out_valid | out_ready);

  // RAM write port is a straight pass-through; the RAM samples it on the clock edge.
  assign ram_wre = w_push;
  assign ram_wad = r_wptr;
  assign ram_di  = in_data;
  assign ram_rad = r_rptr;

  // Advance the write/read pointers and track how many words sit in the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= ptr_t'(0);
      r_rptr    <= ptr_t'(0);
      r_ram_cnt <= cnt_t'(0);
    end else begin
      if (w_push) begin
        r_wptr <= ptr_inc(r_wptr);
      end else begin
        r_wptr <= r_wptr;
      end
      if (w_load) begin
        r_rptr <= ptr_inc(r_rptr);
      end else begin
        r_rptr <= r_rptr;
      end
      case ({w_push, w_load})
        2'b10:   r_ram_cnt <= r_ram_cnt + cnt_t'(1);
        2'b01:   r_ram_cnt <= r_ram_cnt - cnt_t'(1);
        default: r_ram_cnt <= r_ram_cnt;
      endcase
    end
  end

  dpram_fifo_outreg #(
    .WIDTH(WIDTH)
  ) u_outreg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_out_ready (out_ready),
    .i_ram_q     (ram_q),
    .o_out_valid (w_out_valid),
    .o_out_data  (out_data)
  );

  assign out_valid = w_out_valid;

`ifdef DPRAM_FIFO_LEVEL_EN
  // Total occupancy built only from registered state.
  assign level = LVL_W'(r_ram_cnt) + LVL_W'(w_out_valid);
`endif

endmodule
